// File: rtl/esc_tx_ctrl.sv
// C-PHY escape-mode TX controller: LP entry/exit sequencing, command + LPDT bytes to the serializer, per-byte TxReadyEsc.
// Outputs registered, one byte per 8 cycles back-to-back; a missing payload byte parks the line in PAUSE. ULPS under `ESC_ULPS_EN.
module esc_tx_ctrl #(
    parameter int         LP_STATE_CYCLES = 2,
    parameter logic [7:0] CMD_LPDT        = 8'h87,
    parameter logic [7:0] CMD_RST_TRIG    = 8'h46,
    parameter logic [7:0] CMD_ULPS        = 8'h78
) (
    input  logic       i_TxClkEsc,
    input  logic       i_rst,
    input  logic       i_TxRequestEsc,
    input  logic       i_TxLpdtEsc,
    input  logic       i_TxUlpsEsc,
    input  logic [3:0] i_TxTriggerEsc,
    input  logic [7:0] i_TxDataEsc,
    input  logic       i_TxValidEsc,
    output logic       o_TxReadyEsc,
    input  logic       i_SerLastBit,
    output logic       o_EscSerEn,
    output logic [7:0] o_SerDataEsc,
    output logic [1:0] o_LpDrv,
    output logic       o_EscBusy
);

    localparam int            CW     = (LP_STATE_CYCLES > 1) ? $clog2(LP_STATE_CYCLES) : 1;
    localparam logic [CW-1:0] LP_MAX = CW'(LP_STATE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ENTRY, ST_CMD, ST_DATA, ST_PAUSE, ST_EXIT, ST_ULPS
    } state_t;

    typedef enum logic [1:0] {
        TY_LPDT, TY_TRIG, TY_ULPS
    } type_t;

    state_t      r_state;
    type_t       r_type;
    logic        r_req_d;
    logic [CW-1:0] r_lp_cnt;
    logic [1:0]  r_phase;
    logic        r_TxReadyEsc;
    logic        r_EscSerEn;
    logic [7:0]  r_SerDataEsc;
    logic [1:0]  r_LpDrv;
    logic        r_EscBusy;

    logic        w_start_vld;
    type_t       w_start_type;
    logic [7:0]  w_cmd;
    logic [1:0]  w_entry_lp;
    logic        w_lp_done;

`ifdef ESC_ULPS_EN
    localparam logic [9:0] WAKE_MAX = 10'd999;
    logic        r_waking;
    logic [9:0]  r_wake_cnt;
    logic        w_unused;
    assign w_unused = ^i_TxTriggerEsc[3:1];
`else
    logic        w_unused;
    assign w_unused = ^{i_TxTriggerEsc[3:1], i_TxUlpsEsc};
`endif

    assign w_lp_done = (r_lp_cnt == LP_MAX);

    // Request type priority: LPDT, then ULPS (when built in), then reset trigger.
    always_comb begin
        w_start_vld  = 1'b0;
        w_start_type = TY_LPDT;
        if (i_TxLpdtEsc) begin
            w_start_vld  = 1'b1;
            w_start_type = TY_LPDT;
        end
`ifdef ESC_ULPS_EN
        else if (i_TxUlpsEsc) begin
            w_start_vld  = 1'b1;
            w_start_type = TY_ULPS;
        end
`endif
        else if (i_TxTriggerEsc[0]) begin
            w_start_vld  = 1'b1;
            w_start_type = TY_TRIG;
        end
    end

    always_comb begin
        w_cmd = CMD_LPDT;
        case (r_type)
            TY_LPDT: w_cmd = CMD_LPDT;
            TY_TRIG: w_cmd = CMD_RST_TRIG;
            TY_ULPS: w_cmd = CMD_ULPS;
            default: w_cmd = CMD_LPDT;
        endcase
    end

    // Line code of the entry phase that follows the current one (10 -> 00 -> 01 -> 00).
    always_comb begin
        w_entry_lp = 2'b00;
        case (r_phase)
            2'd0:    w_entry_lp = 2'b00;
            2'd1:    w_entry_lp = 2'b01;
            default: w_entry_lp = 2'b00;
        endcase
    end

    always_ff @(posedge i_TxClkEsc or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_type       <= TY_LPDT;
            r_req_d      <= 1'b0;
            r_lp_cnt     <= '0;
            r_phase      <= 2'd0;
            r_TxReadyEsc <= 1'b0;
            r_EscSerEn   <= 1'b0;
            r_SerDataEsc <= 8'h00;
            r_LpDrv      <= 2'b11;
            r_EscBusy    <= 1'b0;
`ifdef ESC_ULPS_EN
            r_waking     <= 1'b0;
            r_wake_cnt   <= 10'd0;
`endif
        end else begin
            r_req_d      <= i_TxRequestEsc;
            r_TxReadyEsc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_TxRequestEsc && !r_req_d && w_start_vld) begin
                        r_type    <= w_start_type;
                        r_state   <= ST_ENTRY;
                        r_LpDrv   <= 2'b10;
                        r_EscBusy <= 1'b1;
                        r_lp_cnt  <= '0;
                        r_phase   <= 2'd0;
                    end
                end

                ST_ENTRY: begin
                    if (!i_TxRequestEsc) begin
                        r_state  <= ST_EXIT;
                        r_LpDrv  <= 2'b10;
                        r_lp_cnt <= '0;
                    end else if (w_lp_done) begin
                        r_lp_cnt <= '0;
                        if (r_phase == 2'd3) begin
                            r_state      <= ST_CMD;
                            r_EscSerEn   <= 1'b1;
                            r_SerDataEsc <= w_cmd;
                        end else begin
                            r_phase <= r_phase + 2'd1;
                            r_LpDrv <= w_entry_lp;
                        end
                    end else begin
                        r_lp_cnt <= r_lp_cnt + 1'b1;
                    end
                end

                ST_CMD: begin
                    if (i_SerLastBit) begin
                        r_lp_cnt <= '0;
                        case (r_type)
                            TY_LPDT: begin
                                if (i_TxValidEsc) begin
                                    r_SerDataEsc <= i_TxDataEsc;
                                    r_TxReadyEsc <= 1'b1;
                                    r_state      <= ST_DATA;
                                end else begin
                                    r_EscSerEn <= 1'b0;
                                    r_LpDrv    <= 2'b00;
                                    r_state    <= ST_PAUSE;
                                end
                            end
`ifdef ESC_ULPS_EN
                            TY_ULPS: begin
                                r_EscSerEn <= 1'b0;
                                r_LpDrv    <= 2'b00;
                                r_waking   <= 1'b0;
                                r_wake_cnt <= 10'd0;
                                r_state    <= ST_ULPS;
                            end
`endif
                            default: begin
                                r_EscSerEn <= 1'b0;
                                r_LpDrv    <= 2'b10;
                                r_state    <= ST_EXIT;
                            end
                        endcase
                    end
                end

                // The request is only looked at on byte boundaries so a byte is never cut short.
                ST_DATA: begin
                    if (i_SerLastBit) begin
                        r_lp_cnt <= '0;
                        if (!i_TxRequestEsc) begin
                            r_EscSerEn <= 1'b0;
                            r_LpDrv    <= 2'b10;
                            r_state    <= ST_EXIT;
                        end else if (!i_TxValidEsc) begin
                            r_EscSerEn <= 1'b0;
                            r_LpDrv    <= 2'b00;
                            r_state    <= ST_PAUSE;
                        end else begin
                            r_SerDataEsc <= i_TxDataEsc;
                            r_TxReadyEsc <= 1'b1;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (!i_TxRequestEsc) begin
                        r_LpDrv  <= 2'b10;
                        r_lp_cnt <= '0;
                        r_state  <= ST_EXIT;
                    end else if (i_TxValidEsc) begin
                        r_SerDataEsc <= i_TxDataEsc;
                        r_EscSerEn   <= 1'b1;
                        r_TxReadyEsc <= 1'b1;
                        r_state      <= ST_DATA;
                    end
                end

                ST_EXIT: begin
                    if (w_lp_done) begin
                        r_LpDrv   <= 2'b11;
                        r_EscBusy <= 1'b0;
                        r_lp_cnt  <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_lp_cnt <= r_lp_cnt + 1'b1;
                    end
                end

`ifdef ESC_ULPS_EN
                // Hold 00 while requested; on release drive the 10 wakeup for 1000 cycles before the normal exit.
                ST_ULPS: begin
                    if (!r_waking) begin
                        if (!i_TxRequestEsc) begin
                            r_waking   <= 1'b1;
                            r_wake_cnt <= 10'd0;
                            r_LpDrv    <= 2'b10;
                        end
                    end else if (r_wake_cnt == WAKE_MAX) begin
                        r_waking <= 1'b0;
                        r_lp_cnt <= '0;
                        r_state  <= ST_EXIT;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 10'd1;
                    end
                end
`endif

                default: begin
                    r_state    <= ST_IDLE;
                    r_EscSerEn <= 1'b0;
                    r_LpDrv    <= 2'b11;
                    r_EscBusy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_TxReadyEsc = r_TxReadyEsc;
    assign o_EscSerEn   = r_EscSerEn;
    assign o_SerDataEsc = r_SerDataEsc;
    assign o_LpDrv      = r_LpDrv;
    assign o_EscBusy    = r_EscBusy;

endmodule

// File: tb/tb_esc_tx_ctrl.sv
// Scoreboard bench for esc_tx_ctrl: serializer model, line-state run-length monitor and TxReadyEsc monitor.
module tb_esc_tx_ctrl;

    localparam int LP = 2;

    logic       clk;
    logic       rst;
    logic       req;
    logic       lpdt;
    logic       ulps;
    logic [3:0] trig;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       last_bit;
    logic       ser_en;
    logic [7:0] ser_data;
    logic [1:0] lp_drv;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_err = 0;
    int rdy_err  = 0;

    // Expected line runs: {token, length}; token 3'b100 = serializer active, else {0, LpDrv}. Length 0 never used.
    logic [18:0] exp_seg[$];
    logic [7:0]  exp_byte[$];
    logic [7:0]  exp_rdy[$];

    esc_tx_ctrl #(.LP_STATE_CYCLES(LP)) dut (
        .i_TxClkEsc    (clk),
        .i_rst         (rst),
        .i_TxRequestEsc(req),
        .i_TxLpdtEsc   (lpdt),
        .i_TxUlpsEsc   (ulps),
        .i_TxTriggerEsc(trig),
        .i_TxDataEsc   (tx_data),
        .i_TxValidEsc  (tx_valid),
        .o_TxReadyEsc  (tx_ready),
        .i_SerLastBit  (last_bit),
        .o_EscSerEn    (ser_en),
        .o_SerDataEsc  (ser_data),
        .o_LpDrv       (lp_drv),
        .o_EscBusy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_seg(input logic [2:0] tok, input int len);
        exp_seg.push_back({tok, 16'(len)});
    endtask

    task automatic push_entry();
        push_seg(3'b010, LP);
        push_seg(3'b000, LP);
        push_seg(3'b001, LP);
        push_seg(3'b000, LP);
    endtask

    // Serializer model: captures on the first enabled cycle, LastBit during the 8th bit.
    initial begin
        logic [2:0] bitidx;
        logic [2:0] pos;
        bitidx   = 3'd0;
        last_bit = 1'b0;
        forever begin
            @(negedge clk);
            pos = ser_en ? bitidx : 3'd0;
            if (ser_en && pos == 3'd0) begin
                if (exp_byte.size() == 0) chk("ser_byte_unexpected", {24'd0, ser_data}, 32'hFFFF_FFFF);
                else chk("ser_byte", {24'd0, ser_data}, {24'd0, exp_byte.pop_front()});
            end
            last_bit = ser_en && (pos == 3'd7);
            bitidx   = ser_en ? pos + 3'd1 : 3'd0;
        end
    end

    // Line-state run-length monitor; idle (11) runs are not scored.
    initial begin
        logic [2:0] cur_tok;
        logic [2:0] tok;
        int         cur_len;
        logic [18:0] e;
        cur_tok = 3'b011;
        cur_len = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cur_tok = 3'b011;
                cur_len = 0;
            end else begin
                tok = ser_en ? 3'b100 : {1'b0, lp_drv};
                if (busy != (tok != 3'b011)) busy_err++;
                if (tok == cur_tok) cur_len++;
                else begin
                    if (cur_tok != 3'b011) begin
                        if (exp_seg.size() == 0) chk("seg_unexpected", {13'd0, cur_tok, 16'(cur_len)}, 32'hFFFF_FFFF);
                        else begin
                            e = exp_seg.pop_front();
                            chk("seg", {13'd0, cur_tok, 16'(cur_len)}, {13'd0, e});
                        end
                    end
                    cur_tok = tok;
                    cur_len = 1;
                end
            end
        end
    end

    // TxReadyEsc monitor: each pulse must present the offered byte to the serializer.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && tx_ready) begin
                if (prev) rdy_err++;
                if (exp_rdy.size() == 0) chk("rdy_unexpected", 32'd1, 32'd0);
                else chk("rdy_byte", {24'd0, ser_data}, {24'd0, exp_rdy.pop_front()});
            end
            prev = tx_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rdy(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_ready) begin seen = 1; break; end
        end
        if (!seen) chk(name, 32'd0, 32'd1);
    endtask

    task automatic wait_ser(input logic lvl, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ser_en == lvl) begin seen = 1; break; end
        end
        if (!seen) chk(name, {31'd0, ~lvl}, {31'd0, lvl});
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin seen = 1; break; end
        end
        if (!seen) chk(name, 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_seg_left"},  exp_seg.size(),  0);
        chk({name, "_byte_left"}, exp_byte.size(), 0);
        chk({name, "_rdy_left"},  exp_rdy.size(),  0);
    endtask

    initial begin
        bit busy_seen;
        rst = 1'b0; req = 1'b0; lpdt = 1'b0; ulps = 1'b0; trig = 4'd0;
        tx_data = 8'h00; tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_lpdrv",  {30'd0, lp_drv}, 32'd3);
        chk("rst_seren",  {31'd0, ser_en}, 32'd0);
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_ready",  {31'd0, tx_ready}, 32'd0);
        chk("rst_serdat", {24'd0, ser_data}, 32'd0);

        // LPDT, two bytes back to back
        push_entry(); push_seg(3'b100, 24); push_seg(3'b010, LP);
        exp_byte.push_back(8'h87); exp_byte.push_back(8'hA5); exp_byte.push_back(8'h3C);
        exp_rdy.push_back(8'hA5); exp_rdy.push_back(8'h3C);
        lpdt = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1; req = 1'b1;
        wait_rdy("lpdt_rdy1_timeout");
        tx_data = 8'h3C;
        wait_rdy("lpdt_rdy2_timeout");
        req = 1'b0; tx_valid = 1'b0; lpdt = 1'b0;
        wait_idle(100, "lpdt_idle_timeout");
        chk_drained("lpdt");

        // LPDT with a 5-cycle pause between payload bytes
        push_entry(); push_seg(3'b100, 16); push_seg(3'b000, 5); push_seg(3'b100, 8); push_seg(3'b010, LP);
        exp_byte.push_back(8'h87); exp_byte.push_back(8'h11); exp_byte.push_back(8'h22);
        exp_rdy.push_back(8'h11); exp_rdy.push_back(8'h22);
        lpdt = 1'b1; tx_data = 8'h11; tx_valid = 1'b1; req = 1'b1;
        wait_rdy("gap_rdy1_timeout");
        tx_valid = 1'b0;
        wait_ser(1'b0, "gap_pause_timeout");
        repeat (4) @(negedge clk);
        tx_data = 8'h22; tx_valid = 1'b1;
        wait_rdy("gap_rdy2_timeout");
        req = 1'b0; tx_valid = 1'b0; lpdt = 1'b0;
        wait_idle(100, "gap_idle_timeout");
        chk_drained("gap");

        // Reset trigger: command only, no payload handshake
        push_entry(); push_seg(3'b100, 8); push_seg(3'b010, LP);
        exp_byte.push_back(8'h46);
        trig = 4'b0001; req = 1'b1;
        wait_idle(100, "trig_idle_timeout");
        req = 1'b0; trig = 4'd0;
        repeat (2) @(negedge clk);
        chk_drained("trig");

        // Request dropped in the middle of a payload byte
        push_entry(); push_seg(3'b100, 16); push_seg(3'b010, LP);
        exp_byte.push_back(8'h87); exp_byte.push_back(8'h5A);
        exp_rdy.push_back(8'h5A);
        lpdt = 1'b1; tx_data = 8'h5A; tx_valid = 1'b1; req = 1'b1;
        wait_rdy("drop_rdy_timeout");
        repeat (3) @(negedge clk);
        req = 1'b0;
        wait_idle(100, "drop_idle_timeout");
        tx_valid = 1'b0; lpdt = 1'b0;
        chk_drained("drop");

`ifdef ESC_ULPS_EN
        push_entry(); push_seg(3'b100, 8); push_seg(3'b000, 11); push_seg(3'b010, 1000 + LP);
        exp_byte.push_back(8'h78);
        ulps = 1'b1; req = 1'b1;
        wait_ser(1'b1, "ulps_ser_timeout");
        wait_ser(1'b0, "ulps_cmd_timeout");
        repeat (10) @(negedge clk);
        req = 1'b0; ulps = 1'b0;
        wait_idle(1200, "ulps_idle_timeout");
        chk_drained("ulps");
`else
        busy_seen = 0;
        ulps = 1'b1; req = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        chk("ulps_disabled_busy", {31'd0, busy_seen}, 32'd0);
        req = 1'b0; ulps = 1'b0;
        repeat (3) @(negedge clk);
`endif

        // Reset while the command byte is on the wire
        push_entry();
        exp_byte.push_back(8'h87);
        lpdt = 1'b1; tx_valid = 1'b0; req = 1'b1;
        wait_ser(1'b1, "rstmid_ser_timeout");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_lpdrv",  {30'd0, lp_drv}, 32'd3);
        chk("rstmid_seren",  {31'd0, ser_en}, 32'd0);
        chk("rstmid_busy",   {31'd0, busy},   32'd0);
        chk("rstmid_ready",  {31'd0, tx_ready}, 32'd0);
        chk("rstmid_serdat", {24'd0, ser_data}, 32'd0);
        req = 1'b0; lpdt = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk_drained("rstmid");

        chk("busy_vs_line_errors", busy_err, 0);
        chk("ready_back_to_back",  rdy_err,  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/esc_tx_ctrl.md
Name: esc_tx_ctrl

Overview:
- Escape-mode transmit controller for the C-PHY master.
- Accepts PPI escape requests (LPDT, trigger, ULPS) in the TxClkEsc domain and drives the LP entry/exit line sequence.
- Feeds the entry command byte, then the payload bytes, to the escape serializer through its enable/LastBit handshake.
- Returns per-byte TxReadyEsc to the PPI.

Parameters:
- LP_STATE_CYCLES, 2, TxClkEsc cycles each LP state is held during entry/exit; legal range >= 1.
- CMD_LPDT, 8'h87, LPDT entry command, bit0 transmitted first.
- CMD_RST_TRIG, 8'h46, reset-trigger entry command, bit0 first.
- CMD_ULPS, 8'h78, ULPS entry command, bit0 first.

Ports:
- TxClkEsc  in  1  escape clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- TxRequestEsc  in  1  PPI escape request; level, held for the whole transaction.
- TxLpdtEsc  in  1  request type LPDT (sampled at request start).
- TxUlpsEsc  in  1  request type ULPS (sampled at request start).
- TxTriggerEsc  in  4  trigger select; only bit0 (reset trigger) is supported.
- TxDataEsc  in  8  LPDT payload byte.
- TxValidEsc  in  1  TxDataEsc valid.
- TxReadyEsc  out  1  one-cycle pulse: current TxDataEsc byte accepted.
- SerLastBit  in  1  serializer LastBit (high during the 8th bit).
- EscSerEn  out  1  serializer enable.
- SerDataEsc  out  8  byte presented to the serializer.
- LpDrv  out  2  LP line state code: 11 = Stop, 10, 01, 00.
- EscBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: EscSerEn=0, SerDataEsc=0, TxReadyEsc=0, LpDrv=2'b11, EscBusy=0, FSM=IDLE, all counters 0.
- Reset mid-operation aborts immediately to these values. No exit sequence is driven.
- Serializer contract:
  - The serializer captures SerDataEsc on the first cycle EscSerEn is high, and on the cycle after each SerLastBit while EscSerEn stays high.
  - A byte therefore occupies exactly 8 cycles.
- FSM states: IDLE, ENTRY, CMD, DATA, PAUSE, EXIT, ULPS.
- IDLE:
  - Wait for a rising TxRequestEsc.
  - Latch type with priority: TxLpdtEsc, then TxUlpsEsc, then TxTriggerEsc[0].
  - Request with no valid type: ignore and stay in IDLE.
- ENTRY:
  - Drive LpDrv 10, 00, 01, 00, each for LP_STATE_CYCLES, then go to CMD.
  - TxRequestEsc dropping during ENTRY goes to EXIT.
- CMD:
  - SerDataEsc = selected command; EscSerEn = 1; LpDrv follows the serializer (don't-care here).
  - On SerLastBit:
    - LPDT with TxValidEsc=1: load TxDataEsc into SerDataEsc, pulse TxReadyEsc, go to DATA; EscSerEn stays 1 (back-to-back).
    - LPDT with TxValidEsc=0: EscSerEn=0, go to PAUSE.
    - Trigger: EscSerEn=0, go to EXIT.
    - ULPS: EscSerEn=0, go to ULPS.
- DATA:
  - On SerLastBit with TxValidEsc=1 and TxRequestEsc=1: load the next byte and pulse TxReadyEsc in that same cycle.
  - On SerLastBit with TxValidEsc=0: EscSerEn=0, go to PAUSE.
  - On SerLastBit with TxRequestEsc=0: EscSerEn=0, go to EXIT.
  - TxRequestEsc is only evaluated at byte boundaries. A byte is never truncated.
- PAUSE:
  - LpDrv=00.
  - TxValidEsc=1: load byte, EscSerEn=1, pulse TxReadyEsc, go to DATA.
  - TxRequestEsc=0: go to EXIT.
  - If both hold in the same cycle, EXIT wins.
- EXIT: LpDrv 10 for LP_STATE_CYCLES, then 11, then IDLE. The EscBusy falling edge coincides with LpDrv returning to 11.
- TxReadyEsc is never high in two consecutive cycles, and is never high outside CMD/DATA/PAUSE.
- The LP state counter saturates at LP_STATE_CYCLES-1 and is cleared on every state change.

Optional Feature:
- Macro: ESC_ULPS_EN.
- Defined:
  - The ULPS state is present; LpDrv=00 while TxRequestEsc=1.
  - On TxRequestEsc falling: hold LpDrv=10 for 1000 TxClkEsc cycles (wakeup), then go to EXIT.
- Not defined:
  - TxUlpsEsc is ignored in IDLE; the ULPS state and the wakeup counter are not synthesized.
  - A request carrying only TxUlpsEsc stays in IDLE.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> LpDrv=11, EscSerEn=0, EscBusy=0, TxReadyEsc=0.
- LPDT, 2 bytes (8'hA5, 8'h3C) with TxValidEsc held -> LpDrv 10/00/01/00 for 2 cycles each; serial stream is 8'h87, 8'hA5, 8'h3C LSB-first with no gap; TxReadyEsc pulses exactly twice; exit LpDrv 10 then 11.
- LPDT with TxValidEsc low for 5 cycles between bytes -> EscSerEn=0 and LpDrv=00 during the gap; resumes with the next byte; exactly one TxReadyEsc per byte.
- Reset trigger (TxTriggerEsc=4'b0001) -> entry, 8'h46 serialized, straight to EXIT; TxReadyEsc never asserted.
- TxRequestEsc dropped mid-byte -> current byte completes all 8 bits, then EXIT. Separately, rst asserted mid-CMD -> all outputs return to reset values immediately.
- ULPS: with ESC_ULPS_EN, 8'h78 sent, then LpDrv=00; on request drop, 1000 cycles of 10, then 11. Without ESC_ULPS_EN, EscBusy stays 0.
